mem_burst_master: RTL
=====================

Name: mem_burst_master

Overview:
- Initiator for the single-port, synchronous-read word memory (16-bit words, 2^WIDTH entries).
- Accepts one burst command at a time over a valid/ready request channel.
  - Write bursts stream data in over a valid/ready channel.
  - Read bursts stream data out over a valid/ready response channel with backpressure.
- Drives memoryWrite, memoryRead, memoryAddress and memoryWriteData, and samples memoryOutData, using the memory's 1-cycle registered-read timing.
- Sits between the datapath and the memory block.

Parameters:
WIDTH, 8, address width; data width is 2*WIDTH; burst length up to 2^WIDTH words

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  synchronous active-high reset
req_valid  in  1  burst command valid
req_ready  out  1  command accepted when req_valid&&req_ready
req_write  in  1  1=write burst, 0=read burst
req_addr  in  WIDTH  start address
req_len  in  WIDTH  burst length minus one (0 => 1 word, 2^WIDTH-1 => 2^WIDTH words)
wdata_valid  in  1  write word valid
wdata_ready  out  1  write word accepted on wdata_valid&&wdata_ready
wdata  in  2*WIDTH  write word
rdata_valid  out  1  read word valid
rdata_ready  in  1  consumer ready
rdata  out  2*WIDTH  read word
rdata_last  out  1  marks final word of read burst (qualified by rdata_valid)
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse after the last word of a burst completes
memoryWrite  out  1  memory write enable
memoryRead  out  1  memory read-output enable
memoryAddress  out  WIDTH  memory address
memoryWriteData  out  2*WIDTH  memory write data
memoryOutData  in  2*WIDTH  memory read data (registered mem[addr] of previous cycle, gated by memoryRead)

Behaviour:
- Reset, synchronous: state=IDLE; rdata=0, rdata_valid=0, rdata_last=0, done=0, busy=0; address and count registers =0; memoryWrite=0, memoryRead=0.
- Reset mid-burst aborts immediately: no further memory writes, and any pending rdata is dropped.
- States: IDLE, WR, RD_ADDR, RD_CAP, RD_RESP.
- IDLE:
  - req_ready=1; all other handshakes low.
  - On accept, register addr<=req_addr, cnt<=req_len, dir<=req_write.
  - Next state is WR if req_write, else RD_ADDR.
- WR:
  - wdata_ready=1. memoryAddress=addr; memoryWriteData=wdata.
  - memoryWrite=wdata_valid (combinational, same cycle); the word is written at that edge.
  - On each accept:
    - cnt==0 -> IDLE, done=1 next cycle.
    - Otherwise addr<=addr+1 mod 2^WIDTH and cnt<=cnt-1.
  - wdata_valid low: no write, stay in WR. Throughput is 1 word/cycle.
- RD_ADDR: memoryAddress=addr, memoryRead=0; the memory registers mem[addr] at the edge. Next state RD_CAP.
- RD_CAP:
  - memoryRead=1, memoryAddress held at addr.
  - Capture rdata<=memoryOutData, rdata_valid<=1, rdata_last<=(cnt==0). Next state RD_RESP.
- RD_RESP:
  - rdata, rdata_valid and rdata_last are held stable until rdata_ready.
  - On handshake: rdata_valid<=0.
    - If last: go to IDLE, done=1 next cycle.
    - Else: addr<=addr+1 mod 2^WIDTH, cnt<=cnt-1, go to RD_ADDR.
  - Minimum 3 cycles/word.
- memoryRead=0 outside RD_CAP; memoryWrite=0 outside WR.
- Address wrap: 0xFF+1 -> 0x00 for WIDTH=8. The burst continues across the wrap with no error.
- Read-after-write: a read burst started after a write burst's done observes the written data. No overlap is possible, since bursts are serialised.
- A new request arriving during busy is not accepted (req_ready=0); the requester holds req_valid.
- done and IDLE coincide, so req_ready is high in the same cycle done pulses.

Test Plan:
- Reset: assert rst 2 cycles -> all outputs 0 except req_ready=1 on the first cycle after release; memoryWrite/memoryRead=0.
- Write then read: write burst addr=0x10, len=3, data 0x1111,0x2222,0x3333,0x4444, wdata_valid continuous -> 4 memoryWrite cycles at addr 0x10..0x13, done 1 cycle after the 4th.
  - Then read burst addr=0x10, len=3, rdata_ready=1 -> rdata 0x1111..0x4444, rdata_last only on 0x4444, first rdata_valid 3 cycles after accept, 3 cycles/word.
- Wrap: write addr=0xFE, len=3, data 0xA0..0xA3 -> writes at 0xFE,0xFF,0x00,0x01; readback from 0xFE returns 0xA0..0xA3 in order.
- Write gaps: drop wdata_valid for 3 cycles mid-burst -> memoryWrite low during the gap, address not advanced, burst completes correctly.
- Read backpressure: rdata_ready=0 for 5 cycles on word 2 -> rdata and rdata_valid stable for 5 cycles, memoryRead=0 during the stall, no word skipped or duplicated.
- Reset mid-burst: assert rst after 2 of 4 write words -> return to IDLE; the remaining words are never written; a new request is accepted right after rst release.

Source files
------------

// File: rtl/mem_burst_master.sv
// mem_burst_master: burst initiator for a single-port word memory
// with 1-cycle registered read and valid/ready data channels.
module mem_burst_master #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_write,
  input  logic [WIDTH-1:0]   req_addr,
  input  logic [WIDTH-1:0]   req_len,
  input  logic               wdata_valid,
  output logic               wdata_ready,
  input  logic [2*WIDTH-1:0] wdata,
  output logic               rdata_valid,
  input  logic               rdata_ready,
  output logic [2*WIDTH-1:0] rdata,
  output logic               rdata_last,
  output logic               busy,
  output logic               done,
  output logic               memoryWrite,
  output logic               memoryRead,
  output logic [WIDTH-1:0]   memoryAddress,
  output logic [2*WIDTH-1:0] memoryWriteData,
  input  logic [2*WIDTH-1:0] memoryOutData
);

  localparam int DW = 2 * WIDTH;
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD_ADDR,
    RD_CAP,
    RD_RESP
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] addr, addr_n;
  logic [WIDTH-1:0] cnt, cnt_n;
  logic [DW-1:0]    rdata_n;
  logic             rvalid_n, rlast_n, done_n;
  logic             wr_en, rd_en;

  // Reset gates the memory strobes so an aborted burst never touches memory.
  assign memoryWrite = wr_en & ~rst;
  assign memoryRead  = rd_en & ~rst;
  assign busy        = (state != IDLE);

  // Next-state, datapath updates and memory/handshake outputs.
  always_comb begin
    state_n         = state;
    addr_n          = addr;
    cnt_n           = cnt;
    rdata_n         = rdata;
    rvalid_n        = rdata_valid;
    rlast_n         = rdata_last;
    done_n          = 1'b0;
    req_ready       = 1'b0;
    wdata_ready     = 1'b0;
    wr_en           = 1'b0;
    rd_en           = 1'b0;
    memoryAddress   = addr;
    memoryWriteData = '0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          addr_n  = req_addr;
          cnt_n   = req_len;
          state_n = req_write ? WR : RD_ADDR;
        end
      end
      WR: begin
        wdata_ready     = 1'b1;
        memoryWriteData = wdata;
        wr_en           = wdata_valid;
        if (wdata_valid) begin
          if (cnt == '0) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end else begin
            addr_n = addr + ONE;
            cnt_n  = cnt - ONE;
          end
        end
      end
      RD_ADDR: begin
        state_n = RD_CAP;
      end
      RD_CAP: begin
        rd_en    = 1'b1;
        rdata_n  = memoryOutData;
        rvalid_n = 1'b1;
        rlast_n  = (cnt == '0);
        state_n  = RD_RESP;
      end
      RD_RESP: begin
        if (rdata_ready) begin
          rvalid_n = 1'b0;
          if (rdata_last) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end else begin
            addr_n  = addr + ONE;
            cnt_n   = cnt - ONE;
            state_n = RD_ADDR;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      addr        <= '0;
      cnt         <= '0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      rdata_last  <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_n;
      addr        <= addr_n;
      cnt         <= cnt_n;
      rdata       <= rdata_n;
      rdata_valid <= rvalid_n;
      rdata_last  <= rlast_n;
      done        <= done_n;
    end
  end

endmodule
